// File: rtl/memr_row_packer_pkg.sv
// Shared definitions for the R-vector row packer: state encoding, default
// geometry of the row memory, and the lane-slice helper.
package memr_row_packer_pkg;

    localparam int unsigned ELEMENT_WIDTH = 64;
    localparam int unsigned NO_OF_UNITS   = 8;
    localparam int unsigned ADDRESS_WIDTH = 20;
    localparam int unsigned COUNT_WIDTH   = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Bit offset of a lane inside a packed row (lane 0 sits in the LSBs).
    function automatic int unsigned lane_offset(input int unsigned lane,
                                                input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/memr_row_packer.sv
// Packs a serial element stream into no_of_units-wide rows and writes each
// row to consecutive addresses of the row memory.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   start               pulse; latches base_address and num_elements
//   base_address        first row address
//   num_elements        number of elements to pack (0 allowed)
//   in_data/in_valid    element stream; in_ready is high only while filling
//   mem_write_*         row write port (one-cycle strobe per row)
//   busy                high while filling or writing
//   finish              level, high once all elements are stored
module memr_row_packer
    import memr_row_packer_pkg::*;
#(
    parameter int unsigned element_width = ELEMENT_WIDTH,
    parameter int unsigned no_of_units   = NO_OF_UNITS,
    parameter int unsigned address_width = ADDRESS_WIDTH,
    parameter int unsigned count_width   = COUNT_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic [address_width-1:0]               base_address,
    input  logic [count_width-1:0]                 num_elements,
    input  logic [element_width-1:0]               in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [no_of_units*element_width-1:0]   mem_write_data,
    output logic                                   mem_write_en,
    output logic [address_width-1:0]               mem_write_addr,
    output logic                                   busy,
    output logic                                   finish
);

    localparam int unsigned ROW_W  = no_of_units * element_width;
    localparam int unsigned LANE_W = (no_of_units > 1) ? $clog2(no_of_units) : 1;

    state_e                     state_q, state_d;
    logic [LANE_W-1:0]          lane_idx_q, lane_idx_d;
    logic [count_width-1:0]     remaining_q, remaining_d;
    logic [address_width-1:0]   row_addr_q, row_addr_d;
    logic [ROW_W-1:0]           row_q, row_d;
    logic [ROW_W-1:0]           mem_write_data_q, mem_write_data_d;
    logic                       mem_write_en_q, mem_write_en_d;
    logic [address_width-1:0]   mem_write_addr_q, mem_write_addr_d;
    logic                       busy_q, busy_d;
    logic                       finish_q, finish_d;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d          = state_q;
        lane_idx_d       = lane_idx_q;
        remaining_d      = remaining_q;
        row_addr_d       = row_addr_q;
        row_d            = row_q;
        mem_write_data_d = mem_write_data_q;
        mem_write_en_d   = 1'b0;
        mem_write_addr_d = mem_write_addr_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    row_addr_d  = base_address;
                    remaining_d = num_elements;
                    row_d       = '0;
                    lane_idx_d  = '0;
                    state_d     = (num_elements == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    row_d[lane_offset(32'(lane_idx_q), element_width) +: element_width] = in_data;
                    lane_idx_d  = lane_idx_q + LANE_W'(1);
                    remaining_d = remaining_q - count_width'(1);
                    // Row is complete, or this was the last element: write it next cycle.
                    if ((lane_idx_q == LANE_W'(no_of_units - 1)) ||
                        (remaining_q == count_width'(1))) begin
                        state_d          = ST_WRITE;
                        mem_write_en_d   = 1'b1;
                        mem_write_data_d = row_d;
                        mem_write_addr_d = row_addr_q;
                    end
                end
            end
            ST_WRITE: begin
                row_addr_d = row_addr_q + address_width'(1);
                lane_idx_d = '0;
                row_d      = '0;
                state_d    = (remaining_q != '0) ? ST_FILL : ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d   = (state_d == ST_FILL) || (state_d == ST_WRITE);
        finish_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            lane_idx_q       <= '0;
            remaining_q      <= '0;
            row_addr_q       <= '0;
            row_q            <= '0;
            mem_write_data_q <= '0;
            mem_write_en_q   <= 1'b0;
            mem_write_addr_q <= '0;
            busy_q           <= 1'b0;
            finish_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            lane_idx_q       <= lane_idx_d;
            remaining_q      <= remaining_d;
            row_addr_q       <= row_addr_d;
            row_q            <= row_d;
            mem_write_data_q <= mem_write_data_d;
            mem_write_en_q   <= mem_write_en_d;
            mem_write_addr_q <= mem_write_addr_d;
            busy_q           <= busy_d;
            finish_q         <= finish_d;
        end
    end

    assign in_ready       = (state_q == ST_FILL);
    assign mem_write_data = mem_write_data_q;
    assign mem_write_en   = mem_write_en_q;
    assign mem_write_addr = mem_write_addr_q;
    assign busy           = busy_q;
    assign finish         = finish_q;

endmodule

// File: tb/tb_memr_row_packer.sv
// Scoreboard bench for memr_row_packer: stimulus pushes expected row writes,
// a negedge monitor pops and compares every mem_write_en strobe.
module tb_memr_row_packer;

    localparam int unsigned EW = 64;
    localparam int unsigned NU = 8;
    localparam int unsigned AW = 20;
    localparam int unsigned CW = 20;
    localparam int unsigned RW = EW * NU;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   base_address = '0;
    logic [CW-1:0]   num_elements = '0;
    logic [EW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [RW-1:0]   mem_write_data;
    logic            mem_write_en;
    logic [AW-1:0]   mem_write_addr;
    logic            busy;
    logic            finish;

    int              vectors = 0;
    int              errors  = 0;
    int              cyc     = 0;
    int              start_cyc = 0;
    wr_t             exp_q[$];

    memr_row_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_address   (base_address),
        .num_elements   (num_elements),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .busy           (busy),
        .finish         (finish)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [CW-1:0] n);
        start = 1'b1;
        base_address = base;
        num_elements = n;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // Present one element and hold it until accepted (bounded).
    task automatic send(input logic [EW-1:0] v);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) done = 1;
            tick();
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_finish(input string name, input int exp_lat);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (finish) seen = 1;
            else tick();
        end
        chk({name, "_finish"}, RW'(seen), RW'(1));
        if (exp_lat >= 0) chk({name, "_latency"}, RW'(cyc - start_cyc), RW'(exp_lat));
        chk({name, "_busy"}, RW'(busy), RW'(0));
        chk({name, "_pending"}, RW'(exp_q.size()), RW'(0));
    endtask

    task automatic push_row(input logic [AW-1:0] a, input logic [EW-1:0] lanes[NU]);
        wr_t w;
        w.addr = a;
        w.data = '0;
        for (int i = 0; i < NU; i++) w.data[i*EW +: EW] = lanes[i];
        exp_q.push_back(w);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_wen"},    RW'(mem_write_en),   RW'(0));
        chk({name, "_waddr"},  RW'(mem_write_addr), RW'(0));
        chk({name, "_wdata"},  mem_write_data,      RW'(0));
        chk({name, "_busy"},   RW'(busy),           RW'(0));
        chk({name, "_finish"}, RW'(finish),         RW'(0));
        chk({name, "_ready"},  RW'(in_ready),       RW'(0));
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (reset_n && mem_write_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", RW'(mem_write_addr), RW'(0) - RW'(1));
                end else begin
                    w = exp_q.pop_front();
                    chk("write_addr", RW'(mem_write_addr), RW'(w.addr));
                    chk("write_data", mem_write_data, w.data);
                end
                chk("ready_in_write", RW'(in_ready), RW'(0));
            end
        end
    end

    initial begin
        logic [EW-1:0] lanes[NU];

        // Power-on reset.
        reset_n = 1'b0;
        tick(); tick();
        chk_idle_outputs("por");
        reset_n = 1'b1;
        tick();

        // 1: reset mid-FILL after 3 elements discards the partial row.
        do_start(20'h40, 20'd8);
        send(64'h11); send(64'h22); send(64'h33);
        in_valid = 1'b0;
        reset_n = 1'b0;
        tick(); tick();
        chk_idle_outputs("midreset");
        reset_n = 1'b1;
        repeat (4) tick();
        chk_idle_outputs("after_reset");

        // 2: two full rows, in_valid held.
        for (int i = 0; i < NU; i++) lanes[i] = 64'(i + 1);
        push_row(20'h10, lanes);
        for (int i = 0; i < NU; i++) lanes[i] = 64'(i + 9);
        push_row(20'h11, lanes);
        do_start(20'h10, 20'd16);
        for (int i = 1; i <= 16; i++) send(64'(i));
        in_valid = 1'b0;
        wait_finish("two_rows", 18);

        // 3: partial row, unfilled lanes zero.
        for (int i = 0; i < NU; i++) lanes[i] = '0;
        lanes[0] = 64'hAAAA_AAAA_0000_000A;
        lanes[1] = 64'hBBBB_BBBB_0000_000B;
        lanes[2] = 64'hCCCC_CCCC_0000_000C;
        push_row(20'h5, lanes);
        do_start(20'h5, 20'd3);
        send(lanes[0]); send(lanes[1]); send(lanes[2]);
        in_valid = 1'b0;
        wait_finish("partial", 4);

        // 4: zero elements -> finish next cycle, never ready.
        do_start(20'h77, 20'd0);
        chk("zero_finish", RW'(finish), RW'(1));
        chk("zero_ready", RW'(in_ready), RW'(0));
        in_valid = 1'b1;
        repeat (3) tick();
        chk("zero_ready_held", RW'(in_ready), RW'(0));
        in_valid = 1'b0;
        wait_finish("zero", -1);

        // 5: address wrap at top of the address space.
        for (int i = 0; i < NU; i++) lanes[i] = 64'h5000 + 64'(i);
        push_row(20'hFFFFF, lanes);
        for (int i = 0; i < NU; i++) lanes[i] = '0;
        lanes[0] = 64'h5008;
        push_row(20'h00000, lanes);
        do_start(20'hFFFFF, 20'd9);
        for (int i = 0; i < 9; i++) send(64'h5000 + 64'(i));
        in_valid = 1'b0;
        wait_finish("wrap", -1);

        // 6: valid gaps and stray start pulses during FILL.
        for (int i = 0; i < NU; i++) lanes[i] = 64'hDEAD_0000 + 64'(i);
        push_row(20'h20, lanes);
        do_start(20'h20, 20'd8);
        for (int i = 0; i < NU; i++) begin
            int gap = int'($urandom_range(0, 3));
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                start = (g == 0);
                base_address = 20'h99;
                num_elements = 20'd1;
                tick();
            end
            start = 1'b0;
            send(64'hDEAD_0000 + 64'(i));
        end
        in_valid = 1'b0;
        wait_finish("gaps", -1);
        repeat (3) tick();
        chk("gaps_no_extra", RW'(exp_q.size()), RW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
